// File: rtl/isp1362_xfer_seq.sv
// Transfer sequencer for the ISP1362 bus controller: one command phase followed by
// N data phases over the controller's Go/Done handshake, with a per-phase watchdog.
module isp1362_xfer_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             iClk200,
  input  logic             iReset,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic [7:0]       iReqCmd,
  input  logic             iReqRead,
  input  logic [CNT_W-1:0] iReqLen,
  input  logic [15:0]      iWrData,
  input  logic             iWrValid,
  output logic             oWrReady,
  output logic [15:0]      oRdData,
  output logic             oRdValid,
  output logic             oBusy,
  output logic             oErr,
  output logic             oCtrlCmd,
  output logic             oCtrlRead,
  output logic [15:0]      oCtrlD,
  output logic             oCtrlGo,
  input  logic             iCtrlDone,
  input  logic [15:0]      iCtrlQ
);

  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO,
    S_ARM1,
    S_ARM2,
    S_WAIT,
    S_FETCH
  } state_e;

  state_e           state_q, state_d;
  logic             data_ph_q, data_ph_d;
  logic             read_q, read_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             ctrl_cmd_q, ctrl_cmd_d;
  logic             ctrl_read_q, ctrl_read_d;
  logic [15:0]      ctrl_dat_q, ctrl_dat_d;
  logic             ctrl_go_q, ctrl_go_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rem_dec;
  logic [WD_W-1:0]  wdog_inc;
  logic             wdog_run;
  logic             wdog_expire;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    data_ph_d   = data_ph_q;
    read_d      = read_q;
    rem_d       = rem_q;
    wdog_d      = wdog_q;
    ctrl_cmd_d  = ctrl_cmd_q;
    ctrl_read_d = ctrl_read_q;
    ctrl_dat_d  = ctrl_dat_q;
    ctrl_go_d   = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;

    rem_dec     = (data_ph_q && (rem_q != '0)) ? rem_q - 1'b1 : rem_q;
    wdog_inc    = wdog_q + 1'b1;
    wdog_run    = (state_q == S_GO) || (state_q == S_ARM1) ||
                  (state_q == S_ARM2) || (state_q == S_WAIT);
    wdog_expire = wdog_run && (wdog_inc == WD_W'(TIMEOUT));

    if (wdog_run) wdog_d = wdog_inc;

    unique case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          read_d      = iReqRead;
          rem_d       = iReqLen;
          data_ph_d   = 1'b0;
          ctrl_cmd_d  = 1'b1;
          ctrl_read_d = 1'b0;
          ctrl_dat_d  = {8'h00, iReqCmd};
          wdog_d      = '0;
          state_d     = S_GO;
        end
      end
      // Done high here means the controller is idle, so Go cannot interrupt an access.
      S_GO: begin
        if (iCtrlDone) begin
          ctrl_go_d = 1'b1;
          state_d   = S_ARM1;
        end
      end
      S_ARM1: state_d = S_ARM2;
      S_ARM2: state_d = S_WAIT;
      S_WAIT: begin
        if (iCtrlDone) begin
          rem_d  = rem_dec;
          wdog_d = '0;
          if (data_ph_q && read_q) begin
            rd_data_d  = iCtrlQ;
            rd_valid_d = 1'b1;
          end
          if (rem_dec == '0) begin
            state_d = S_IDLE;
          end else if (read_q) begin
            data_ph_d   = 1'b1;
            ctrl_cmd_d  = 1'b0;
            ctrl_read_d = 1'b1;
            state_d     = S_GO;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (iWrValid) begin
          ctrl_dat_d  = iWrData;
          ctrl_cmd_d  = 1'b0;
          ctrl_read_d = 1'b0;
          data_ph_d   = 1'b1;
          wdog_d      = '0;
          state_d     = S_GO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A Done arriving on the expiry cycle still completes the phase.
    if (wdog_expire && !((state_q == S_WAIT) && iCtrlDone)) begin
      err_d       = 1'b1;
      ctrl_go_d   = 1'b0;
      ctrl_cmd_d  = 1'b0;
      ctrl_read_d = 1'b0;
      rem_d       = '0;
      wdog_d      = '0;
      state_d     = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iClk200) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      data_ph_q   <= 1'b0;
      read_q      <= 1'b0;
      rem_q       <= '0;
      wdog_q      <= '0;
      ctrl_cmd_q  <= 1'b0;
      ctrl_read_q <= 1'b0;
      ctrl_dat_q  <= 16'h0000;
      ctrl_go_q   <= 1'b0;
      rd_data_q   <= 16'h0000;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_ph_q   <= data_ph_d;
      read_q      <= read_d;
      rem_q       <= rem_d;
      wdog_q      <= wdog_d;
      ctrl_cmd_q  <= ctrl_cmd_d;
      ctrl_read_q <= ctrl_read_d;
      ctrl_dat_q  <= ctrl_dat_d;
      ctrl_go_q   <= ctrl_go_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  assign oReqReady = (state_q == S_IDLE);
  assign oWrReady  = (state_q == S_FETCH);
  assign oBusy     = (state_q != S_IDLE);
  assign oRdData   = rd_data_q;
  assign oRdValid  = rd_valid_q;
  assign oErr      = err_q;
  assign oCtrlCmd  = ctrl_cmd_q;
  assign oCtrlRead = ctrl_read_q;
  assign oCtrlD    = ctrl_dat_q;
  assign oCtrlGo   = ctrl_go_q;

endmodule

// File: tb/tb_isp1362_xfer_seq.sv
// Bench for isp1362_xfer_seq: behavioural controller and write source, expected-phase
// scoreboard, directed scenarios followed by randomized requests.
module tb_isp1362_xfer_seq;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic        cmd;
    logic        rd;
    logic [15:0] d;
  } phase_t;

  logic             clk = 1'b0;
  logic             iReset, iReqValid, oReqReady, iReqRead;
  logic [7:0]       iReqCmd;
  logic [CNT_W-1:0] iReqLen;
  logic [15:0]      iWrData, oRdData, oCtrlD, iCtrlQ;
  logic             iWrValid, oWrReady, oRdValid, oBusy, oErr;
  logic             oCtrlCmd, oCtrlRead, oCtrlGo, iCtrlDone;

  always #5 clk = ~clk;

  isp1362_xfer_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk200(clk), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqCmd(iReqCmd),
    .iReqRead(iReqRead), .iReqLen(iReqLen),
    .iWrData(iWrData), .iWrValid(iWrValid), .oWrReady(oWrReady),
    .oRdData(oRdData), .oRdValid(oRdValid), .oBusy(oBusy), .oErr(oErr),
    .oCtrlCmd(oCtrlCmd), .oCtrlRead(oCtrlRead), .oCtrlD(oCtrlD), .oCtrlGo(oCtrlGo),
    .iCtrlDone(iCtrlDone), .iCtrlQ(iCtrlQ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state shared by the environment processes.
  phase_t      exp_ph[$];
  logic [15:0] exp_rd[$];
  logic [15:0] q_force[$];
  logic [15:0] wfix[$];
  logic [15:0] wr_q[$];
  int          wr_stall_q[$];
  int          go_cnt = 0, rd_cnt = 0, err_cnt = 0;
  int          lat_min = 1, lat_max = 8;
  bit          hang = 1'b0;

  // Controller model: Done drops after Go is sampled and returns after a random latency.
  initial begin
    phase_t      cur, e;
    int          cnt;
    bit          hold_ok;
    logic [15:0] q_next;
    iCtrlDone = 1'b1;
    iCtrlQ    = 16'h0000;
    forever begin
      @(negedge clk);
      if (oCtrlGo) begin
        go_cnt++;
        check("go_while_done", iCtrlDone, 1);
        cur = {oCtrlCmd, oCtrlRead, oCtrlD};
        check("go_expected", exp_ph.size() != 0, 1);
        if (exp_ph.size() != 0) begin
          e = exp_ph.pop_front();
          if (e.rd && !e.cmd) check("go_sel", {cur.cmd, cur.rd}, {e.cmd, e.rd});
          else                check("go_fields", 32'(cur), 32'(e));
        end
        q_next = 16'($urandom);
        if (q_force.size() != 0) q_next = q_force.pop_front();
        if (cur.rd && !cur.cmd) exp_rd.push_back(q_next);
        @(negedge clk);
        check("go_gap", oCtrlGo, 0);
        iCtrlDone = 1'b0;
        hold_ok   = 1'b1;
        cnt       = $urandom_range(lat_max, lat_min);
        while (hang || cnt > 0) begin
          @(negedge clk);
          check("go_while_busy", oCtrlGo, 0);
          if (!oBusy) hold_ok = 1'b0;
          if (hold_ok) check("ctrl_hold", 32'({oCtrlCmd, oCtrlRead, oCtrlD}), 32'(cur));
          cnt--;
        end
        iCtrlQ    = q_next;
        iCtrlDone = 1'b1;
      end
    end
  end

  // Read-data and error monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (oRdValid) begin
        rd_cnt++;
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rd_data", oRdData, exp_rd.pop_front());
      end
      if (oErr) err_cnt++;
    end
  end

  // Write source: each queued word waits its stall count before being offered.
  initial begin
    bit fire;
    int stall;
    iWrValid = 1'b0;
    iWrData  = 16'h0000;
    fire     = 1'b0;
    stall    = -1;
    forever begin
      @(negedge clk);
      if (fire) begin
        void'(wr_q.pop_front());
        void'(wr_stall_q.pop_front());
        stall = -1;
      end
      if (wr_q.size() != 0 && stall < 0) stall = wr_stall_q[0];
      if (wr_q.size() != 0 && stall == 0) begin
        iWrValid = 1'b1;
        iWrData  = wr_q[0];
      end else begin
        iWrValid = 1'b0;
        if (stall > 0) stall--;
      end
      fire = iWrValid && oWrReady;
    end
  end

  task automatic push_req(input logic [7:0] cmd, input bit rd, input int len,
                          input int stall_lo, input int stall_hi);
    logic [15:0] w;
    exp_ph.push_back(phase_t'{cmd: 1'b1, rd: 1'b0, d: {8'h00, cmd}});
    for (int i = 0; i < len; i++) begin
      if (rd) begin
        exp_ph.push_back(phase_t'{cmd: 1'b0, rd: 1'b1, d: 16'h0000});
      end else begin
        if (wfix.size() != 0) w = wfix.pop_front();
        else                  w = 16'($urandom);
        exp_ph.push_back(phase_t'{cmd: 1'b0, rd: 1'b0, d: w});
        wr_q.push_back(w);
        wr_stall_q.push_back((i == 0) ? 0 : int'($urandom_range(stall_hi, stall_lo)));
      end
    end
  endtask

  task automatic offer(input logic [7:0] cmd, input bit rd, input int len);
    int t;
    @(negedge clk);
    iReqValid = 1'b1;
    iReqCmd   = cmd;
    iReqRead  = rd;
    iReqLen   = CNT_W'(len);
    t = 0;
    while (!oReqReady && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("req_accept", oReqReady, 1);
  endtask

  task automatic wait_idle(input int go0, input int rd0, input int err0,
                           input int n_ph, input int n_rd);
    int t;
    t = 0;
    while (oBusy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", oBusy, 0);
    check("ready_after", oReqReady, 1);
    @(negedge clk);
    check("go_count", go_cnt - go0, n_ph);
    check("rd_count", rd_cnt - rd0, n_rd);
    check("no_err", err_cnt - err0, 0);
    check("ph_drained", exp_ph.size(), 0);
    check("rd_drained", exp_rd.size(), 0);
  endtask

  task automatic run_req(input logic [7:0] cmd, input bit rd, input int len,
                         input int stall_lo, input int stall_hi, input bit chk_go_lat);
    int go0, rd0, err0;
    logic done_at_acc;
    go0  = go_cnt;
    rd0  = rd_cnt;
    err0 = err_cnt;
    push_req(cmd, rd, len, stall_lo, stall_hi);
    offer(cmd, rd, len);
    done_at_acc = iCtrlDone;
    @(negedge clk);
    iReqValid = 1'b0;
    if (chk_go_lat && done_at_acc) begin
      @(negedge clk);
      check("go_latency", oCtrlGo, 1);
    end
    wait_idle(go0, rd0, err0, len + 1, rd ? len : 0);
  endtask

  task automatic check_rst_vals();
    check("rst_go", oCtrlGo, 0);
    check("rst_rdvalid", oRdValid, 0);
    check("rst_err", oErr, 0);
    check("rst_wrready", oWrReady, 0);
    check("rst_busy", oBusy, 0);
    check("rst_reqready", oReqReady, 1);
    check("rst_cmd", oCtrlCmd, 0);
    check("rst_read", oCtrlRead, 0);
    check("rst_ctrld", oCtrlD, 16'h0000);
    check("rst_rddata", oRdData, 16'h0000);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int go0, rd0, err0, t;
    iReset    = 1'b1;
    iReqValid = 1'b0;
    iReqCmd   = 8'h00;
    iReqRead  = 1'b0;
    iReqLen   = '0;
    repeat (3) @(negedge clk);
    check_rst_vals();
    iReset = 1'b0;

    // Command only, slow controller.
    lat_min = 78; lat_max = 78;
    run_req(8'hB5, 1'b0, 0, 0, 0, 1'b1);

    // Read three known words.
    lat_min = 5; lat_max = 5;
    q_force.push_back(16'h1111); q_force.push_back(16'h1111);
    q_force.delete();
    q_force.push_back(16'h0000);  // consumed by the command phase
    q_force.push_back(16'h1111);
    q_force.push_back(16'h2222);
    q_force.push_back(16'h3333);
    run_req(8'hF0, 1'b1, 3, 0, 0, 1'b0);

    // Write two words with a 20-cycle source stall between them.
    lat_min = 2; lat_max = 2;
    wfix.push_back(16'hA5A5);
    wfix.push_back(16'h5A5A);
    run_req(8'h3C, 1'b0, 2, 20, 20, 1'b0);

    // Watchdog abort: controller never returns Done.
    hang = 1'b1;
    err0 = err_cnt;
    exp_ph.push_back(phase_t'{cmd: 1'b1, rd: 1'b0, d: 16'h0077});
    offer(8'h77, 1'b1, 2);
    @(negedge clk);
    iReqValid = 1'b0;
    t = 1;
    while (!oErr && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("err_delay_ok", (t >= 254 && t <= 258), 1);
    check("err_ready", oReqReady, 1);
    check("err_busy", oBusy, 0);
    check("err_cmd", oCtrlCmd, 0);
    check("err_read", oCtrlRead, 0);
    @(negedge clk);
    check("err_pulse", oErr, 0);
    check("err_count", err_cnt - err0, 1);
    hang = 1'b0;
    t = 0;
    while (!iCtrlDone && t < 100) begin
      @(negedge clk);
      t++;
    end
    exp_ph.delete();
    exp_rd.delete();

    // Reset during the second read data phase, then a new request straight away.
    lat_min = 40; lat_max = 40;
    go0 = go_cnt;
    push_req(8'h5C, 1'b1, 3, 0, 0);
    offer(8'h5C, 1'b1, 3);
    @(negedge clk);
    iReqValid = 1'b0;
    t = 0;
    while (go_cnt < go0 + 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach_d2", go_cnt - go0, 3);
    repeat (10) @(negedge clk);
    check("rst_ctrl_inflight", iCtrlDone, 0);
    iReset = 1'b1;
    @(negedge clk);
    check_rst_vals();
    iReset = 1'b0;
    exp_ph.delete();
    exp_rd.delete();
    lat_min = 1; lat_max = 4;
    run_req(8'h3A, 1'b0, 0, 0, 0, 1'b0);

    // Back-to-back: write len 1 then read len 1 with valid held high.
    go0 = go_cnt; rd0 = rd_cnt; err0 = err_cnt;
    push_req(8'h11, 1'b0, 1, 0, 0);
    push_req(8'h22, 1'b1, 1, 0, 0);
    offer(8'h11, 1'b0, 1);
    @(negedge clk);
    iReqCmd  = 8'h22;
    iReqRead = 1'b1;
    t = 0;
    while (!oReqReady && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done", go_cnt - go0, 2);
    @(negedge clk);
    check("b2b_accept", oBusy, 1);
    iReqValid = 1'b0;
    wait_idle(go0, rd0, err0, 4, 1);

    // Maximum length read.
    lat_min = 1; lat_max = 2;
    run_req(8'hC3, 1'b1, 255, 0, 0, 1'b0);

    // Randomized requests.
    for (int k = 0; k < 30; k++) begin
      lat_min = 1;
      lat_max = $urandom_range(12, 1);
      run_req(8'($urandom), 1'($urandom), $urandom_range(4, 0), 0, $urandom_range(6, 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
